// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_pkg;
  localparam int XLEN  = 64;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_multiplier_if.sv
// Start/done handshake and operand/result bus of seq_multiplier.
// MUL_SIGNED_EN adds the is_signed request qualifier.
interface seq_multiplier_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
`ifdef MUL_SIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

`ifdef MUL_SIGNED_EN
  modport master (output start, op_a, op_b, is_signed,
                  input  busy, done, result_lo, result_hi);
  modport slave  (input  start, op_a, op_b, is_signed,
                  output busy, done, result_lo, result_hi);
`else
  modport master (output start, op_a, op_b,
                  input  busy, done, result_lo, result_hi);
  modport slave  (input  start, op_a, op_b,
                  output busy, done, result_lo, result_hi);
`endif
endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into hi, then shift {carry,hi,lo} right by one.
module mul_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, mcand_i} : '0);
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/seq_multiplier.sv
// Iterative 64x64->128 multiplier, one multiplier bit per clock; done pulses 65 edges after start.
// MUL_SIGNED_EN enables two's-complement operands via is_signed.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CNT_W = mul_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_multiplier_if.slave bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] ld_a, ld_b;
  logic [2*WIDTH-1:0] prod_raw, prod;
  logic             last_step;

  assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign prod_raw  = {step_hi, step_lo};

`ifdef MUL_SIGNED_EN
  logic neg_q, ld_neg;

  // Most-negative input negates to itself, which read unsigned is the correct magnitude.
  always_comb begin
    ld_a   = bus.op_a;
    ld_b   = bus.op_b;
    ld_neg = 1'b0;
    if (bus.is_signed) begin
      ld_a   = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
      ld_b   = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
      ld_neg = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
    end
  end

  assign prod = neg_q ? -prod_raw : prod_raw;
`else
  assign ld_a = bus.op_a;
  assign ld_b = bus.op_b;
  assign prod = prod_raw;
`endif

  mul_step #(.WIDTH(WIDTH)) u_step (
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .mcand_i (mcand_q),
    .hi_o    (step_hi),
    .lo_o    (step_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == RUN);
    bus.done      = (state_q == DONE);
    bus.result_lo = res_lo_q;
    bus.result_hi = res_hi_q;
  end

  // Results only move on the final step so partial products never reach the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
`ifdef MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q <= ld_a;
            lo_q    <= ld_b;
            hi_q    <= '0;
            cnt_q   <= '0;
`ifdef MUL_SIGNED_EN
            neg_q   <= ld_neg;
`endif
          end
        end
        RUN: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step) begin
            res_hi_q <= prod[2*WIDTH-1:WIDTH];
            res_lo_q <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier; signed cases are built in when MUL_SIGNED_EN is defined.
module tb_seq_multiplier;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [63:0] prev_lo, prev_hi;

  seq_multiplier_if #(.WIDTH(64)) bus ();

  seq_multiplier #(.WIDTH(64), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one multiply and follows it to completion, checking latency, busy length,
  // output hold during RUN, the product and the single-cycle done pulse.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input bit sgn, input logic [63:0] eh, input logic [63:0] el,
                        input bit inject);
    int busy_n;
    int done_k;
    logic [63:0] cap_lo, cap_hi;
    busy_n = 0;
    done_k = -1;
    cap_lo = '0;
    cap_hi = '0;
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
`ifdef MUL_SIGNED_EN
    bus.is_signed = sgn;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (bus.busy) busy_n++;
      if (inject && k == 10) begin
        bus.op_a  = 64'd7;
        bus.op_b  = 64'd7;
        bus.start = 1'b1;
      end
      if (inject && k == 11) bus.start = 1'b0;
      if (k == 32) begin
        check({tag, "_hold_lo"}, {64'd0, bus.result_lo}, {64'd0, prev_lo});
        check({tag, "_hold_hi"}, {64'd0, bus.result_hi}, {64'd0, prev_hi});
      end
      if (done_k < 0 && bus.done) begin
        done_k = k;
        cap_lo = bus.result_lo;
        cap_hi = bus.result_hi;
      end else if (done_k >= 0 && k == done_k + 1) begin
        check({tag, "_done_pulse"}, {127'd0, bus.done}, 128'd0);
        break;
      end
    end
    check({tag, "_latency"}, 128'(done_k + 1), 128'd65);
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'd64);
    check({tag, "_hi"}, {64'd0, cap_hi}, {64'd0, eh});
    check({tag, "_lo"}, {64'd0, cap_lo}, {64'd0, el});
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    int d_edges[$];
    int wait_n;
    logic [63:0] b2b_lo;
    n_tests   = 0;
    n_fail    = 0;
    prev_lo   = '0;
    prev_hi   = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
`ifdef MUL_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {127'd0, bus.busy}, 128'd0);
    check("rst_done", {127'd0, bus.done}, 128'd0);
    check("rst_lo", {64'd0, bus.result_lo}, 128'd0);
    check("rst_hi", {64'd0, bus.result_hi}, 128'd0);
    rst_n = 1'b1;

    run_op("mul3x5", 64'd3, 64'd5, 1'b0, 64'd0, 64'd15, 1'b0);
    run_op("mul_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 1'b0);
    run_op("mul_zero_inj", 64'd0, 64'h1234, 1'b0, 64'd0, 64'd0, 1'b0);
    run_op("mul_restart", 64'd0, 64'h1234, 1'b0, 64'd0, 64'd0, 1'b1);
    run_op("mul9x5", 64'd9, 64'd5, 1'b0, 64'd0, 64'd45, 1'b0);

    // Abort at RUN cycle 30 with a nonzero previous result held on the outputs.
    @(negedge clk);
    bus.op_a  = 64'd11;
    bus.op_b  = 64'd13;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", {127'd0, bus.busy}, 128'd0);
    check("abort_done", {127'd0, bus.done}, 128'd0);
    check("abort_lo", {64'd0, bus.result_lo}, 128'd0);
    check("abort_hi", {64'd0, bus.result_hi}, 128'd0);
    prev_lo = '0;
    prev_hi = '0;
    run_op("mul7x6", 64'd7, 64'd6, 1'b0, 64'd0, 64'd42, 1'b0);

    // start held high: done seen at edges 65 and 131 relative to the accepting edge.
    @(negedge clk);
    bus.op_a  = 64'd2;
    bus.op_b  = 64'd9;
    bus.start = 1'b1;
    b2b_lo    = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (bus.done) begin
        d_edges.push_back(k + 1);
        b2b_lo = bus.result_lo;
      end
    end
    bus.start = 1'b0;
    check("b2b_pulses_min", {127'd0, d_edges.size() >= 2}, 128'd1);
    if (d_edges.size() >= 2) begin
      check("b2b_first", 128'(d_edges[0]), 128'd65);
      check("b2b_second", 128'(d_edges[1]), 128'd131);
    end
    check("b2b_lo", {64'd0, b2b_lo}, 128'd18);
    wait_n = 0;
    while ((bus.busy || bus.done) && wait_n < 150) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("b2b_drain", {127'd0, bus.busy | bus.done}, 128'd0);
    prev_lo = 64'd18;
    prev_hi = 64'd0;

    run_op("mulm3x5_u", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0,
           64'd4, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
`ifdef MUL_SIGNED_EN
    run_op("mulm3x5_s", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op("mulmin_s", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
           64'd0, 64'h8000_0000_0000_0000, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
